irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Programmable interrupt controller between the device IRQ lines (timer0, timer1, external
//  interrupt, future devices) and the CPU HWInt[7:2] input. Latches/masks requests per
//  source, exposes PENDING/MASK/MODE/ID registers as a bridge device, drives HWInt.
//  One bridge DEV slot; WE arrives already address-qualified by the bridge.
// PARAMETERS
//  N_SRC       6      number of IRQ sources, legal 1..6; src[i] drives HWInt[i+2]
//  RESET_MASK  6'h00  MASK register value after reset (bit i enables source i)
// PORTS
//  clk     in   1         system clock
//  reset   in   1         synchronous, active-high reset
//  src     in   N_SRC     raw IRQ inputs: {.., interrupt, DEV1_IRQ, DEV0_IRQ}
//  Addr    in   [31:2]    word address from bridge; only Addr[3:2] decoded
//  WE      in   1         register write strobe (bridge-qualified)
//  Din     in   32        write data
//  Dout    out  32        read data, combinational on Addr[3:2]
//  HWInt   out  [7:2]     to CPU; bits above N_SRC+1 tied 0
// BEHAVIOUR
//  Clock and reset: single clock clk; reset is synchronous and active-high.
//  Reset: pending=0, mask=RESET_MASK, mode=0 (all edge), prev=0, sync flops=0. HWInt=0 after reset edge.
//  Register map (Addr[3:2]):
//   00 PENDING  R; W1C: bit i=1 clears pending[i] (edge-mode sources only)
//   01 MASK     RW, bits [N_SRC-1:0]; upper bits read 0
//   10 MODE     RW; bit i 0=edge (latched), 1=level (pending[i] follows input)
//   11 ID       R; index of lowest-numbered bit of pending&mask; 32'hFFFF_FFFF if none; writes ignored
//  s = src as sampled (after sync stage when IRQ_SYNC_EN). prev <= s every cycle.
//  Edge mode: rise[i]=s[i]&~prev[i]; at clk edge pending[i] <= rise[i] | (pending[i] & ~clr[i]).
//   Set beats clear: W1C and a new rise in the same cycle leave pending[i]=1.
//   Held-high input sets once; it must drop and rise again to re-latch.
//  Level mode: pending[i] <= s[i] each cycle; W1C ignored.
//  MODE write edge->level: pending[i] follows s next cycle. Level->edge: pending[i] keeps current
//   value, prev keeps updating (no spurious rise).
//  HWInt[i+2] = registered (pending[i] & mask[i]); mask change visible on HWInt next cycle,
//   pending kept while masked.
//  Latency (no sync): src high before edge k -> pending=1 after k -> HWInt=1 after edge k+1 (2 cycles).
//  Priority: lower index wins in ID (timer0 > timer1 > external).
//  Dout unaffected by WE in the same cycle (reads pre-write value); unused Addr codes none.
//  Reset mid-operation: all state cleared on the reset edge regardless of WE/src; src high during
//   reset is not latched unless it rises after reset (prev also reset to 0, so a held-high edge
//   source WILL latch on the first post-reset cycle, by design: no request lost).
// CONFIGURATION
//  IRQ_SYNC_EN defined: two-flop synchronizer on src before edge logic; total latency 4 cycles;
//   sync flops reset to 0. Required when any src is asynchronous to clk.
//  IRQ_SYNC_EN undefined: s=src directly; latency 2 cycles; all src must be clk-synchronous.
// TESTING
//  1 reset; MASK=3'b111; pulse src[0] 1 cycle -> HWInt[2]=1 two cycles later, ID=0, PENDING=1.
//  2 src[0],src[1] rise together -> ID=0; W1C PENDING=1 -> ID=1; W1C 2 -> ID=FFFF_FFFF, HWInt=0.
//  3 MASK=0, pulse src[1] -> HWInt=0, PENDING=2; write MASK=2 -> HWInt[3]=1 next cycle.
//  4 W1C bit0 in same cycle as new src[0] rise -> PENDING[0] stays 1, HWInt[2] stays 1.
//  5 MODE=4 (src2 level): hold src[2] 5 cycles -> HWInt[4] high 5 cycles (2-cycle lag); W1C ignored.
//  6 reset asserted while PENDING=7, MASK=7 -> next cycle all regs reset, HWInt=0; repeat 1 with
//    IRQ_SYNC_EN -> HWInt[2] after 4 cycles.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level latching, masking, priority ID and a
// registered HWInt[7:2] output. Define IRQ_SYNC_EN to add a two-flop src synchronizer.
module irq_ctrl #(
  parameter int          N_SRC      = 6,
  parameter logic [5:0]  RESET_MASK = 6'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [7:2]       HWInt
);

  typedef enum logic [1:0] {
    REG_PENDING = 2'b00,
    REG_MASK    = 2'b01,
    REG_MODE    = 2'b10,
    REG_ID      = 2'b11
  } reg_sel_e;

  reg_sel_e         sel;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] hw_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic [31:0]      id;
  logic [5:0]       hw_full;
  logic             unused;

  assign sel    = reg_sel_e'(Addr[3:2]);
  assign unused = ^{Addr[31:4], Din[31:N_SRC]};

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = src;
`endif

  assign rise   = s & ~prev;
  assign clr    = (WE && sel == REG_PENDING) ? Din[N_SRC-1:0] : '0;
  assign active = pending & mask;

  // Level sources track s directly; edge sources latch a rise, and a rise beats a W1C.
  // NOTE: every flop below uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      pending <= '0;
      mask    <= RESET_MASK[N_SRC-1:0];
      mode    <= '0;
      hw_q    <= '0;
    end else begin
      prev    <= s;
      pending <= (mode & s) | (~mode & (rise | (pending & ~clr)));
      hw_q    <= active;
      if (WE && sel == REG_MASK) mask <= Din[N_SRC-1:0];
      if (WE && sel == REG_MODE) mode <= Din[N_SRC-1:0];
    end
  end

  // Scan downwards so the lowest-numbered active source is the last (winning) assignment.
  // NOTE: defaults come first in every always_comb so no path leaves a latch behind.
  always_comb begin
    id = 32'hFFFF_FFFF;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) id = 32'(i);
    end
  end

  always_comb begin
    Dout = '0;
    case (sel)
      REG_PENDING: Dout[N_SRC-1:0] = pending;
      REG_MASK:    Dout[N_SRC-1:0] = mask;
      REG_MODE:    Dout[N_SRC-1:0] = mode;
      REG_ID:      Dout            = id;
    endcase
  end

  always_comb begin
    hw_full            = '0;
    hw_full[N_SRC-1:0] = hw_q;
  end

  assign HWInt = hw_full;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a directed vector table for the default build plus
// hand-written latency and mode-switch sequences valid with or without IRQ_SYNC_EN.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src = '0;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic [7:2]  HWInt;

  int checks   = 0;
  int failures = 0;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  irq_ctrl #(.N_SRC(6), .RESET_MASK(6'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .HWInt (HWInt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  src;
    logic        we;
    logic [1:0]  a;
    logic [31:0] din;
    logic        chk;
    logic [31:0] dout;
    logic [5:0]  hw;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [5:0] s, input logic we, input logic [1:0] a,
                     input logic [31:0] din, input logic chk, input logic [31:0] dout,
                     input logic [5:0] hw);
    vec_t v;
    v.rst = rst; v.src = s; v.we = we; v.a = a; v.din = din;
    v.chk = chk; v.dout = dout; v.hw = hw;
    vecs.push_back(v);
  endtask

  function automatic logic [31:2] addr_of(input logic [1:0] a);
    return {28'hA5A5A5A, a};
  endfunction

  // Drive a register access for one cycle; inputs change on the falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = addr_of(a); Din = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0; Din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = addr_of(a);
    #1;
    check(name, Dout, exp);
  endtask

  initial begin : main
    int seen;

    // Each row: inputs applied for the coming edge; dout/hw are the values visible now.
    //   rst src   we a  din            chk dout           hw
    add(1, 6'h0, 0, 0, 32'h0,          0, 32'h0,          6'h0); // 0 reset
    add(0, 6'h0, 1, 1, 32'h7,          1, 32'h0,          6'h0); // 1 MASK reset value, write 7
    add(0, 6'h1, 0, 3, 32'h0,          1, 32'hFFFF_FFFF,  6'h0); // 2 pulse src0
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h1,          6'h0); // 3 pending, hw lags
    add(0, 6'h0, 0, 3, 32'h0,          1, 32'h0,          6'h1); // 4 ID=0, HWInt[2]
    add(0, 6'h3, 0, 0, 32'h0,          1, 32'h1,          6'h1); // 5 src0+src1 rise
    add(0, 6'h0, 0, 3, 32'h0,          1, 32'h0,          6'h1); // 6 ID=0
    add(0, 6'h0, 1, 0, 32'h1,          1, 32'h3,          6'h3); // 7 W1C bit0
    add(0, 6'h0, 0, 3, 32'h0,          1, 32'h1,          6'h3); // 8 ID=1
    add(0, 6'h0, 1, 0, 32'h2,          1, 32'h2,          6'h2); // 9 W1C bit1
    add(0, 6'h0, 0, 3, 32'h0,          1, 32'hFFFF_FFFF,  6'h2); // 10 ID none
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h0,          6'h0); // 11 HWInt cleared
    add(0, 6'h0, 1, 1, 32'h0,          1, 32'h7,          6'h0); // 12 MASK=0
    add(0, 6'h2, 0, 1, 32'h0,          1, 32'h0,          6'h0); // 13 pulse src1 masked
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h2,          6'h0); // 14 pending kept
    add(0, 6'h0, 1, 1, 32'h2,          1, 32'h0,          6'h0); // 15 MASK=2
    add(0, 6'h0, 0, 3, 32'h0,          1, 32'h1,          6'h0); // 16 ID=1, hw next
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h2,          6'h2); // 17 HWInt[3]
    add(0, 6'h1, 1, 1, 32'h7,          1, 32'h2,          6'h2); // 18 MASK=7, src0 rise
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h3,          6'h2); // 19
    add(0, 6'h1, 1, 0, 32'h1,          1, 32'h3,          6'h3); // 20 W1C + rise same cycle
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h3,          6'h3); // 21 set beats clear
    add(0, 6'h1, 0, 3, 32'h0,          1, 32'h0,          6'h3); // 22 rise again
    add(0, 6'h1, 1, 0, 32'h1,          1, 32'h3,          6'h3); // 23 W1C while held
    add(0, 6'h1, 0, 0, 32'h0,          1, 32'h2,          6'h3); // 24 held high: no relatch
    add(0, 6'h0, 1, 0, 32'h2,          1, 32'h2,          6'h2); // 25 W1C bit1
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h0,          6'h2); // 26
    add(0, 6'h0, 1, 2, 32'h4,          1, 32'h0,          6'h0); // 27 MODE=4
    add(0, 6'h4, 0, 2, 32'h0,          1, 32'h4,          6'h0); // 28 src2 high (1/5)
    add(0, 6'h4, 0, 0, 32'h0,          1, 32'h4,          6'h0); // 29 (2/5)
    add(0, 6'h4, 1, 0, 32'h4,          1, 32'h4,          6'h4); // 30 W1C ignored (3/5)
    add(0, 6'h4, 0, 0, 32'h0,          1, 32'h4,          6'h4); // 31 (4/5)
    add(0, 6'h4, 0, 3, 32'h0,          1, 32'h2,          6'h4); // 32 ID=2 (5/5)
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h4,          6'h4); // 33
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h0,          6'h4); // 34 level drops
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h0,          6'h0); // 35 5 cycles total
    add(0, 6'h0, 1, 1, 32'hFFFF_FF81,  1, 32'h7,          6'h0); // 36 upper MASK bits
    add(0, 6'h0, 0, 1, 32'h0,          1, 32'h1,          6'h0); // 37 read back 1
    add(0, 6'h0, 1, 2, 32'h0,          1, 32'h4,          6'h0); // 38 MODE=0
    add(0, 6'h0, 1, 1, 32'h7,          1, 32'h1,          6'h0); // 39 MASK=7
    add(0, 6'h7, 0, 0, 32'h0,          1, 32'h0,          6'h0); // 40 src 0..2 rise
    add(0, 6'h7, 0, 0, 32'h0,          1, 32'h7,          6'h0); // 41 PENDING=7
    add(1, 6'h7, 1, 1, 32'h3F,         1, 32'h7,          6'h7); // 42 reset mid-op
    add(0, 6'h7, 0, 0, 32'h0,          1, 32'h0,          6'h0); // 43 all cleared
    add(0, 6'h0, 0, 1, 32'h0,          1, 32'h0,          6'h0); // 44 MASK back to reset
    add(0, 6'h0, 0, 0, 32'h0,          1, 32'h7,          6'h0); // 45 held src relatched
    add(0, 6'h0, 0, 2, 32'h0,          1, 32'h0,          6'h0); // 46 MODE reset

`ifndef IRQ_SYNC_EN
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      src   = vecs[i].src;
      WE    = vecs[i].we;
      Addr  = addr_of(vecs[i].a);
      Din   = vecs[i].din;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_dout", i), Dout, vecs[i].dout);
        check($sformatf("vec%0d_hwint", i), {26'h0, HWInt}, {26'h0, vecs[i].hw});
      end
    end
`endif

    // Latency: single-cycle pulse on src0 reaches HWInt[2] after LAT edges.
    @(negedge clk);
    reset = 1'b1; WE = 1'b0; src = '0;
    @(negedge clk);
    reset = 1'b0;
    rd_check("post_reset_pending", 2'd0, 32'h0);
    rd_check("post_reset_id", 2'd3, 32'hFFFF_FFFF);
    check("post_reset_hwint", {26'h0, HWInt}, 32'h0);
    wr(2'd1, 32'h7);
    idle(2);
    src  = 6'h1;
    seen = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      src = '0;
      if (HWInt[2] && seen == 0) seen = n;
    end
    check("latency_edges", 32'(seen), 32'(LAT));
    rd_check("latency_id", 2'd3, 32'h0);
    rd_check("latency_pending", 2'd0, 32'h1);
    wr(2'd0, 32'h1);
    idle(2);
    rd_check("latency_cleared", 2'd0, 32'h0);
    check("latency_hw_off", {26'h0, HWInt}, 32'h0);

    // Level->edge switch while input held high: pending stays, no spurious rise after W1C.
    wr(2'd2, 32'h1);
    src = 6'h1;
    idle(LAT + 2);
    rd_check("level_pending", 2'd0, 32'h1);
    wr(2'd2, 32'h0);
    idle(LAT + 2);
    rd_check("edge_keeps_pending", 2'd0, 32'h1);
    wr(2'd0, 32'h1);
    idle(LAT + 2);
    rd_check("no_spurious_rise", 2'd0, 32'h0);
    check("no_spurious_hw", {26'h0, HWInt}, 32'h0);
    src = '0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
